// File: rtl/lane_arbiter_if.sv
// Handshake bundle between the lane scheduler and its surroundings: FIFO status and
// back-pressure in, read strobes, mux valids and status out.
interface lane_arbiter_if #(
    parameter int unsigned CNT_W = 3
) ();
    logic             enable;
    logic             fifo0_empty;
    logic             fifo1_empty;
    logic             out_almost_full;
    logic             pop0;
    logic             pop1;
    logic             mux_valid0;
    logic             mux_valid1;
    logic             grant_lane;
    logic [CNT_W-1:0] burst_cnt;
    logic [1:0]       state_o;

    // Environment side: drives FIFO status and enable, observes the scheduler.
    modport master (
        output enable, fifo0_empty, fifo1_empty, out_almost_full,
        input  pop0, pop1, mux_valid0, mux_valid1, grant_lane, burst_cnt, state_o
    );

    // Scheduler side.
    modport slave (
        input  enable, fifo0_empty, fifo1_empty, out_almost_full,
        output pop0, pop1, mux_valid0, mux_valid1, grant_lane, burst_cnt, state_o
    );
endinterface

// File: rtl/lane_arbiter.sv
// Round-robin read scheduler for the two-lane TX merge mux. Pops one lane FIFO per cycle,
// caps each lane's burst at BURST_MAX when the other lane is waiting, and raises the mux
// valid one cycle after each pop to match the FIFO read latency.
module lane_arbiter #(
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned CNT_W     = 3
) (
    input logic           f2,
    input logic           reset_L,
    lane_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] BurstLast = CNT_W'(BURST_MAX - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             mux_valid0_q, mux_valid1_q;

    logic   go;
    logic   pop0, pop1;
    logic   cur_lane;
    logic   cur_empty, oth_empty;
    state_e oth_state;

    // Read strobes and next-state decision for the scheduler.
    always_comb begin
        go        = bus.enable && !bus.out_almost_full;
        pop0      = (state_q == StGrant0) && go && !bus.fifo0_empty;
        pop1      = (state_q == StGrant1) && go && !bus.fifo1_empty;
        cur_lane  = (state_q == StGrant1);
        cur_empty = cur_lane ? bus.fifo1_empty : bus.fifo0_empty;
        oth_empty = cur_lane ? bus.fifo0_empty : bus.fifo1_empty;
        oth_state = cur_lane ? StGrant0 : StGrant1;
        state_d   = state_q;
        burst_d   = burst_q;
        last_d    = last_q;

        case (state_q)
            StIdle: begin
                // Entry cycle never pops; last_q breaks the tie when both lanes have data.
                if (go) begin
                    if (!bus.fifo0_empty && (bus.fifo1_empty || last_q)) begin
                        state_d = StGrant0;
                    end else if (!bus.fifo1_empty) begin
                        state_d = StGrant1;
                    end
                end
            end
            StGrant0, StGrant1: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                    burst_d = '0;
                    last_d  = cur_lane;
                end else if (bus.out_almost_full) begin
                    // Stall: hold grant and burst count.
                end else if (!cur_empty) begin
                    if (burst_q == BurstLast) begin
                        burst_d = '0;
                        // Forced switch only when the other lane is waiting; no bubble.
                        if (!oth_empty) begin
                            state_d = oth_state;
                            last_d  = cur_lane;
                        end
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end else begin
                    burst_d = '0;
                    last_d  = cur_lane;
                    state_d = oth_empty ? StIdle : oth_state;
                end
            end
            default: begin
                state_d = StIdle;
                burst_d = '0;
            end
        endcase

        // grant_lane tracks the lane of the next state and holds through IDLE.
        case (state_d)
            StGrant0: grant_d = 1'b0;
            StGrant1: grant_d = 1'b1;
            default:  grant_d = grant_q;
        endcase
    end

    // Scheduler state; last_q resets to 1 so lane 0 wins the first grant.
    always_ff @(posedge f2 or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= StIdle;
            burst_q      <= '0;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            mux_valid0_q <= 1'b0;
            mux_valid1_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            mux_valid0_q <= pop0;
            mux_valid1_q <= pop1;
        end
    end

    assign bus.pop0       = pop0;
    assign bus.pop1       = pop1;
    assign bus.mux_valid0 = mux_valid0_q;
    assign bus.mux_valid1 = mux_valid1_q;
    assign bus.grant_lane = grant_q;
    assign bus.burst_cnt  = burst_q;
    assign bus.state_o    = state_q;

endmodule
